// File: rtl/vending_port_arbiter.sv
// vending_port_arbiter
//   Shares one Vending core among NREQ kiosks. After reset it collects
//   PRODUCTNUM prices over a valid/ready handshake while holding the core in
//   reset. It then releases the core and streams the prices on core_di.
//   From then on it serves kiosk purchases one at a time in round-robin order
//   and routes each result back to the kiosk that asked for it.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   cfg_valid/price price entry offered in index order 0..PRODUCTNUM-1
//   cfg_ready       price accepted this cycle (high while collecting)
//   req             per-kiosk request level, held until gnt
//   req_money       per-kiosk money, kiosk i on bits [8i+7:8i]
//   req_sel         per-kiosk product select, kiosk i on bits [2i+1:2i]
//   gnt             one-hot pulse; request data is taken in this cycle
//   rsp_valid       one-hot pulse to the owning kiosk
//   rsp_change      change for the owning kiosk, valid with rsp_valid
//   rsp_product     product for the owning kiosk, valid with rsp_valid
//   core_rst        reset to the Vending core
//   core_di         price stream to the core
//   core_mi         money to the core
//   core_sel        product select to the core
//   core_mo         change returned by the core
//   core_po         product returned by the core
//   busy            high in every state except IDLE

module vending_port_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PRODUCTNUM = 3,
  parameter int unsigned CORE_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_price,
  output logic              cfg_ready,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_money,
  input  logic [NREQ*2-1:0] req_sel,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_change,
  output logic [1:0]        rsp_product,
  output logic              core_rst,
  output logic [7:0]        core_di,
  output logic [7:0]        core_mi,
  output logic [1:0]        core_sel,
  input  logic [7:0]        core_mo,
  input  logic [1:0]        core_po,
  output logic              busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = (PRODUCTNUM > 1) ? $clog2(PRODUCTNUM) : 1;
  localparam int unsigned LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(PRODUCTNUM - 1);
  localparam logic [LW-1:0] LAST_WAIT = LW'(CORE_LAT - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);
  localparam logic [CW-1:0] NREQ_W    = CW'(NREQ);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_STREAM,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [7:0]    price_tab [PRODUCTNUM];
  logic [IW-1:0] idx;
  logic [IW-1:0] scnt;
  logic [LW-1:0] wcnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;

  logic          pick_hit;
  logic [PW-1:0] pick_idx;
  logic [CW-1:0] cand;
  logic [7:0]    money_pick;
  logic [1:0]    sel_pick;

  // Round-robin search: walk ptr, ptr+1, ... modulo NREQ, take the first request.
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!pick_hit && req[cand[PW-1:0]]) begin
        pick_hit = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    money_pick = '0;
    sel_pick   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == PW'(k)) begin
        money_pick = req_money[8*k +: 8];
        sel_pick   = req_sel[2*k +: 2];
      end
    end
  end

  // gnt is decoded from the registered state so it marks the very cycle in
  // which the request data is sampled; this keeps gnt->rsp at CORE_LAT+2.
  always_comb begin
    gnt = '0;
    if (state == S_IDLE && pick_hit) gnt[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_COLLECT;
      cfg_ready   <= 1'b1;
      core_rst    <= 1'b1;
      busy        <= 1'b1;
      core_di     <= '0;
      core_mi     <= '0;
      core_sel    <= '0;
      rsp_valid   <= '0;
      rsp_change  <= '0;
      rsp_product <= '0;
      ptr         <= '0;
      owner       <= '0;
      idx         <= '0;
      scnt        <= '0;
      wcnt        <= '0;
      for (int unsigned i = 0; i < PRODUCTNUM; i++) price_tab[i] <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (cfg_valid) begin
            price_tab[idx] <= cfg_price;
            if (idx == LAST_IDX) begin
              state     <= S_STREAM;
              cfg_ready <= 1'b0;
              core_rst  <= 1'b0;
              scnt      <= '0;
              // With a single entry the first streamed price is the one being accepted.
              core_di   <= (idx == '0) ? cfg_price : price_tab[0];
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        S_STREAM: begin
          if (scnt == LAST_IDX) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            core_di <= '0;
          end else begin
            scnt    <= scnt + IW'(1);
            core_di <= price_tab[scnt + IW'(1)];
          end
        end

        S_IDLE: begin
          if (pick_hit) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            owner    <= pick_idx;
            core_mi  <= money_pick;
            core_sel <= sel_pick;
          end
        end

        S_ISSUE: begin
          core_mi  <= '0;
          core_sel <= '0;
          wcnt     <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wcnt == LAST_WAIT) begin
            state       <= S_RESP;
            rsp_valid   <= NREQ'(1) << owner;
            rsp_change  <= core_mo;
            rsp_product <= core_po;
          end else begin
            wcnt <= wcnt + LW'(1);
          end
        end

        S_RESP: begin
          rsp_valid <= '0;
          ptr       <= (owner == LAST_REQ) ? '0 : owner + PW'(1);
          state     <= S_IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state     <= S_COLLECT;
          cfg_ready <= 1'b1;
          core_rst  <= 1'b1;
          busy      <= 1'b1;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_port_arbiter.sv
// tb_vending_port_arbiter
//   Directed bench for vending_port_arbiter with a behavioural Vending core
//   that learns its prices from the core_di stream and answers after CORE_LAT.

module tb_vending_port_arbiter;

  localparam int NREQ     = 4;
  localparam int PNUM     = 3;
  localparam int CORE_LAT = 1;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic [7:0]        cfg_price;
  logic              cfg_ready;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_money;
  logic [NREQ*2-1:0] req_sel;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_change;
  logic [1:0]        rsp_product;
  logic              core_rst;
  logic [7:0]        core_di;
  logic [7:0]        core_mi;
  logic [1:0]        core_sel;
  logic [7:0]        core_mo;
  logic [1:0]        core_po;
  logic              busy;

  int tests = 0;
  int fails = 0;

  vending_port_arbiter #(
    .NREQ(NREQ),
    .PRODUCTNUM(PNUM),
    .CORE_LAT(CORE_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_price(cfg_price), .cfg_ready(cfg_ready),
    .req(req), .req_money(req_money), .req_sel(req_sel), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_change(rsp_change), .rsp_product(rsp_product),
    .core_rst(core_rst), .core_di(core_di), .core_mi(core_mi), .core_sel(core_sel),
    .core_mo(core_mo), .core_po(core_po), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: records the first PNUM core_di values after core_rst
  // drops, then answers MI/SEL with CORE_LAT cycles of delay.
  logic [7:0] mp [1:3];
  int         mcnt = 0;
  logic [7:0] mo_now;
  logic [1:0] po_now;
  logic [7:0] mo_pipe [CORE_LAT];
  logic [1:0] po_pipe [CORE_LAT];

  always_comb begin
    mo_now = core_mi;
    po_now = 2'd0;
    if (core_sel != 2'd0 && core_mi >= mp[core_sel]) begin
      mo_now = core_mi - mp[core_sel];
      po_now = core_sel;
    end
  end

  always @(posedge clk) begin
    if (core_rst) mcnt <= 0;
    else if (mcnt < PNUM) begin
      mp[mcnt+1] <= core_di;
      mcnt       <= mcnt + 1;
    end
    mo_pipe[0] <= mo_now;
    po_pipe[0] <= po_now;
    for (int i = 1; i < CORE_LAT; i++) begin
      mo_pipe[i] <= mo_pipe[i-1];
      po_pipe[i] <= po_pipe[i-1];
    end
  end

  assign core_mo = mo_pipe[CORE_LAT-1];
  assign core_po = po_pipe[CORE_LAT-1];

  task automatic step_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step_drive();
    rst = 1'b1;
    step_drive();
    @(negedge clk);
    tests++;
    if ({cfg_ready, core_rst, busy} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ctrl: got ready/core_rst/busy=%b required 111", {cfg_ready, core_rst, busy});
    end
    tests++;
    if ({gnt, rsp_valid, core_di, core_mi, core_sel} !== '0) begin
      fails++;
      $display("FAIL reset_data: gnt=%b rsp=%b di=%h mi=%h sel=%h required all zero",
               gnt, rsp_valid, core_di, core_mi, core_sel);
    end
    step_drive();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load(input string name);
    logic [7:0] p [3];
    p[0] = 8'd10; p[1] = 8'd20; p[2] = 8'd30;
    for (int i = 0; i < 3; i++) begin
      step_drive();
      cfg_valid = 1'b1;
      cfg_price = p[i];
      @(negedge clk);
      tests++;
      if ({cfg_ready, core_rst, rsp_valid} !== {2'b11, 4'b0000}) begin
        fails++;
        $display("FAIL %s_collect%0d: got ready=%b core_rst=%b rsp=%b required 1 1 0000",
                 name, i, cfg_ready, core_rst, rsp_valid);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step_drive();
      cfg_valid = 1'b0;
      cfg_price = 8'd0;
      @(negedge clk);
      tests++;
      if ({core_rst, cfg_ready, busy, core_di} !== {3'b001, p[k]}) begin
        fails++;
        $display("FAIL %s_stream%0d: got core_rst=%b ready=%b busy=%b di=%0d required 0 0 1 %0d",
                 name, k, core_rst, cfg_ready, busy, core_di, p[k]);
      end
    end
    step_drive();
    @(negedge clk);
    tests++;
    if ({busy, core_di} !== 9'd0) begin
      fails++;
      $display("FAIL %s_idle: got busy=%b di=%0d required 0 0", name, busy, core_di);
    end
  endtask

  // One purchase by a single kiosk; expects gnt to kiosk k and the result CORE_LAT+2 later.
  task automatic run_sale(input int k, input logic [7:0] m, input logic [1:0] s,
                          input logic [7:0] ec, input logic [1:0] ep, input string name);
    logic [NREQ-1:0] eg;
    int c;
    eg = NREQ'(1) << k;
    step_drive();
    req = eg;
    req_money = '0;
    req_sel = '0;
    req_money[8*k +: 8] = m;
    req_sel[2*k +: 2] = s;
    @(negedge clk);
    for (c = 0; c < 8 && gnt == '0; c++) begin
      step_drive();
      @(negedge clk);
    end
    tests++;
    if (gnt !== eg) begin
      fails++;
      $display("FAIL %s_gnt: got %b required %b", name, gnt, eg);
    end
    step_drive();
    req = '0;
    @(negedge clk);
    tests++;
    if ({core_mi, core_sel, busy} !== {m, s, 1'b1}) begin
      fails++;
      $display("FAIL %s_issue: got mi=%0d sel=%0d busy=%b required %0d %0d 1",
               name, core_mi, core_sel, busy, m, s);
    end
    for (int d = 0; d < CORE_LAT; d++) begin
      step_drive();
      @(negedge clk);
      tests++;
      if ({rsp_valid, core_mi, core_sel} !== '0) begin
        fails++;
        $display("FAIL %s_wait%0d: got rsp=%b mi=%0d sel=%0d required 0 0 0",
                 name, d, rsp_valid, core_mi, core_sel);
      end
    end
    step_drive();
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_change, rsp_product} !== {eg, ec, ep}) begin
      fails++;
      $display("FAIL %s_rsp: got valid=%b change=%0d product=%0d required %b %0d %0d",
               name, rsp_valid, rsp_change, rsp_product, eg, ec, ep);
    end
  endtask

  task automatic test_round_robin;
    int order [5];
    logic [NREQ-1:0] eg;
    int c;
    order = '{0, 1, 2, 3, 0};
    for (int n = 0; n < 5; n++) begin
      eg = NREQ'(1) << order[n];
      step_drive();
      if (n == 0) begin
        req = '1;
        req_money = {NREQ{8'd50}};
        req_sel = {NREQ{2'd3}};
      end
      @(negedge clk);
      for (c = 0; c < 8 && gnt == '0; c++) begin
        step_drive();
        @(negedge clk);
      end
      tests++;
      if (gnt !== eg || c != 0) begin
        fails++;
        $display("FAIL rr_gnt%0d: got %b after %0d idle cycles required %b after 0",
                 n, gnt, c, eg);
      end
      for (int d = 1; d <= CORE_LAT + 2; d++) begin
        step_drive();
        if (n == 4 && d == 1) req = '0;
        @(negedge clk);
        if (d < CORE_LAT + 2) begin
          tests++;
          if (rsp_valid !== '0) begin
            fails++;
            $display("FAIL rr_early%0d: got rsp=%b at +%0d required 0000", n, rsp_valid, d);
          end
        end else begin
          tests++;
          if ({rsp_valid, rsp_change, rsp_product} !== {eg, 8'd20, 2'd3}) begin
            fails++;
            $display("FAIL rr_rsp%0d: got valid=%b change=%0d product=%0d required %b 20 3",
                     n, rsp_valid, rsp_change, rsp_product, eg);
          end
        end
      end
    end
  endtask

  task automatic test_single;
    run_sale(0, 8'd25, 2'd1, 8'd15, 2'd1, "single");
  endtask

  task automatic test_no_sale;
    run_sale(2, 8'd5, 2'd2, 8'd5, 2'd0, "nosale");
  endtask

  task automatic test_rst_in_wait;
    step_drive();
    req = 4'b0010;
    req_money = '0;
    req_sel = '0;
    req_money[15:8] = 8'd40;
    req_sel[3:2] = 2'd1;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0010) begin
      fails++;
      $display("FAIL rstw_gnt: got %b required 0010", gnt);
    end
    step_drive();
    req = '0;
    step_drive();
    rst = 1'b1;
    step_drive();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({rsp_valid, core_rst, cfg_ready, busy, core_mi} !== {4'b0000, 3'b111, 8'd0}) begin
      fails++;
      $display("FAIL rstw_reset: got rsp=%b core_rst=%b ready=%b busy=%b mi=%0d required 0000 1 1 1 0",
               rsp_valid, core_rst, cfg_ready, busy, core_mi);
    end
    step_drive();
    @(negedge clk);
    tests++;
    if ({rsp_valid, cfg_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL rstw_norsp: got rsp=%b ready=%b required 0000 1", rsp_valid, cfg_ready);
    end
    test_load("reload");
  endtask

  task automatic test_cfg_ignored;
    for (int i = 0; i < 3; i++) begin
      step_drive();
      cfg_valid = 1'b1;
      cfg_price = 8'd99;
      @(negedge clk);
      tests++;
      if ({cfg_ready, busy, core_rst, core_di} !== 11'd0) begin
        fails++;
        $display("FAIL cfgign%0d: got ready=%b busy=%b core_rst=%b di=%0d required 0 0 0 0",
                 i, cfg_ready, busy, core_rst, core_di);
      end
    end
    step_drive();
    cfg_valid = 1'b0;
    cfg_price = 8'd0;
    run_sale(3, 8'd35, 2'd2, 8'd15, 2'd2, "cfgign_k3");
    run_sale(0, 8'd30, 2'd3, 8'd0, 2'd3, "exact_wrap_k0");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_price = '0;
    req = '0;
    req_money = '0;
    req_sel = '0;
    test_reset();
    test_load("load");
    test_round_robin();
    test_single();
    test_no_sale();
    test_rst_in_wait();
    test_cfg_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
